alu_serial: RTL

- Parametrised, multi-cycle successor of the team's single-cycle 16-bit ALU.
- Executes one WIDTH-bit operation per transaction, using a SLICE-bit datapath iterated over WIDTH/SLICE cycles.
- Carry, borrow and shift bits chain between slices through a registered carry.
- Valid/ready handshakes on both sides; sits between the sequencer and the register file for wide operands.

---
 rtl/alu_serial.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_serial.sv
// alu_serial: multi-cycle WIDTH-bit ALU built from a SLICE-bit datapath
// that is iterated WIDTH/SLICE times, with the carry chained through a register.
//
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   in_valid, in_ready  : request handshake (in_ready only in IDLE)
//   cmd                 : ADD SUB AND OR XOR XNOR RSHFT COMP (0..7)
//   carry_in, b_inv     : ADD carry / RSHFT fill bit, invert operand B
//   d1, d2              : operands A and B
//   out_valid, out_ready: result handshake (out_valid only in DONE)
//   res, carry_out, zero: result, carry/compare flag, res == 0
module alu_serial #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       cmd,
   input  logic             carry_in,
   input  logic             b_inv,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             carry_out,
   output logic             zero
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] C_ADD  = 3'd0;
   localparam logic [2:0] C_SUB  = 3'd1;
   localparam logic [2:0] C_AND  = 3'd2;
   localparam logic [2:0] C_OR   = 3'd3;
   localparam logic [2:0] C_XOR  = 3'd4;
   localparam logic [2:0] C_XNOR = 3'd5;
   localparam logic [2:0] C_RSH  = 3'd6;
   localparam logic [2:0] C_COMP = 3'd7;

   localparam logic [WIDTH-1:0] SMASK = WIDTH'({SLICE{1'b1}});

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       cmd_q, cmd_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;

   logic [CW-1:0]    idx;
   logic [31:0]      sh;
   logic [SLICE-1:0] a_s, b_s, b_op, r_s;
   logic [SLICE:0]   sum;
   logic             c_n;
   logic [WIDTH-1:0] res_n;
   logic             c_init;

   // RSHFT walks from the MSB slice down so the bit leaving
   // one slice can enter the MSB of the next one.
   always_comb begin
      idx  = (cmd_q == C_RSH) ? (LAST - cnt_q) : cnt_q;
      sh   = 32'(idx) * 32'(SLICE);
      a_s  = SLICE'(a_q >> sh);
      b_s  = SLICE'(b_q >> sh);
      b_op = ((cmd_q == C_SUB) || (cmd_q == C_COMP)) ? ~b_s : b_s;
      sum  = {1'b0, a_s} + {1'b0, b_op} + (SLICE+1)'(carry_q);
      r_s  = '0;
      c_n  = 1'b0;
      unique case (cmd_q)
         C_ADD, C_SUB: begin
            r_s = sum[SLICE-1:0];
            c_n = sum[SLICE];
         end
         C_COMP: c_n = sum[SLICE];
         C_AND:  r_s = a_s & b_s;
         C_OR:   r_s = a_s | b_s;
         C_XOR:  r_s = a_s ^ b_s;
         C_XNOR: r_s = ~(a_s ^ b_s);
         C_RSH: begin
            r_s = (b_s >> 1) | (SLICE'(carry_q) << (SLICE - 1));
            c_n = b_s[0];
         end
         default: ;
      endcase
      res_n = (res_q & ~(SMASK << sh)) | (WIDTH'(r_s) << sh);
   end

   // Initial chained carry: SUB adds 1 to form two's complement,
   // COMP leaves it 0 so the final carry means A > B.
   always_comb begin
      c_init = 1'b0;
      unique case (cmd)
         C_ADD, C_RSH: c_init = carry_in;
         C_SUB:        c_init = 1'b1;
         default:      c_init = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      res_d   = res_q;
      zero_d  = zero_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_BUSY;
               cnt_d   = '0;
               cmd_d   = cmd;
               a_d     = d1;
               b_d     = b_inv ? ~d2 : d2;
               carry_d = c_init;
               res_d   = '0;
               zero_d  = 1'b0;
            end
         end
         S_BUSY: begin
            res_d   = res_n;
            carry_d = c_n;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               zero_d  = (res_n == '0);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cmd_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = (state_q == S_DONE);
   assign res       = res_q;
   assign carry_out = carry_q;
   assign zero      = zero_q;

endmodule
